// File: rtl/ioctl_cart_loader.sv
// ioctl_cart_loader
//   Multi-slot cartridge loader between the hps_io ioctl download stream and
//   the cartridge / EXT RAM write port. Each ioctl_index in
//   [BASE_INDEX, BASE_INDEX+N_SLOTS-1] selects one slot. Incoming bytes are
//   buffered in a small FIFO so the memory side may stall (ioctl_wait), the
//   highest written offset is tracked as the slot size, and the core is held
//   in reset while a load is in flight and for HOLD_CYC cycles afterwards.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout
//                              hps_io download stream (one wr pulse per byte)
//   ioctl_wait                 back-pressure towards hps_io
//   mem_addr/mem_data/mem_we   write request {slot, offset} / byte
//   mem_ack                    write accepted
//   slot_valid                 per slot: holds a completed image
//   slot_size                  per slot byte count, slot 0 in the LSBs
//   overflow                   sticky per download: a byte was dropped
//   core_reset                 hold the core in reset
//
// Memory handshake: mem_we is the valid and mem_ack the ready. A write
// transfers on every clock edge where both are high. While mem_we is high
// without mem_ack, mem_addr and mem_data do not change. mem_ack while mem_we
// is low has no effect.
module ioctl_cart_loader #(
  parameter int N_SLOTS    = 2,
  parameter int SLOT_AW    = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_INDEX = 1,
  parameter int HOLD_CYC   = 16,
  localparam int SW        = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ioctl_download,
  input  logic [7:0]                     ioctl_index,
  input  logic                           ioctl_wr,
  input  logic [24:0]                    ioctl_addr,
  input  logic [7:0]                     ioctl_dout,
  output logic                           ioctl_wait,
  output logic [SW+SLOT_AW-1:0]          mem_addr,
  output logic [7:0]                     mem_data,
  output logic                           mem_we,
  input  logic                           mem_ack,
  output logic [N_SLOTS-1:0]             slot_valid,
  output logic [N_SLOTS*(SLOT_AW+1)-1:0] slot_size,
  output logic                           overflow,
  output logic                           core_reset
);

  localparam int FAW  = $clog2(FIFO_DEPTH);
  localparam int CNTW = FAW + 1;
  localparam int SZW  = SLOT_AW + 1;
  localparam int CW   = $clog2(HOLD_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_HOLD} state_t;

  state_t             state;
  logic [CW-1:0]      hold_cnt;
  logic [SW-1:0]      slot;
  logic [SZW-1:0]     size_q [N_SLOTS];

  logic [SLOT_AW-1:0] fifo_off [FIFO_DEPTH];
  logic [7:0]         fifo_dat [FIFO_DEPTH];
  logic [FAW-1:0]     wr_ptr, rd_ptr;
  logic [CNTW-1:0]    count;

  // Slot decode done in 9 bits so an index below BASE_INDEX cannot wrap.
  logic [8:0]     idx_rel;
  logic           idx_ok;
  logic [SW-1:0]  new_slot;
  assign idx_rel  = {1'b0, ioctl_index} - 9'(BASE_INDEX);
  assign idx_ok   = ({1'b0, ioctl_index} >= 9'(BASE_INDEX)) && (idx_rel < 9'(N_SLOTS));
  assign new_slot = idx_rel[SW-1:0];

  logic           in_range, wr_load, full, pop, push, drop;
  logic [SZW-1:0] off_plus1;
  logic [CNTW-1:0] avail;
  logic [FAW-1:0] next_rd;

  assign in_range  = (ioctl_addr >> SLOT_AW) == 25'd0;
  assign wr_load   = (state == S_LOAD) && ioctl_wr;
  assign full      = (count == CNTW'(FIFO_DEPTH));
  assign pop       = mem_we && mem_ack;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push      = wr_load && in_range && (!full || pop);
  assign drop      = wr_load && !(in_range && (!full || pop));
  assign off_plus1 = {1'b0, ioctl_addr[SLOT_AW-1:0]} + SZW'(1);
  // Entries left after this cycle's pop; the next head follows the popped one.
  assign avail     = count - CNTW'(pop);
  assign next_rd   = rd_ptr + FAW'(pop);

  // One entry of headroom in LOAD; a new download arriving while the previous
  // one finishes is stalled until the FSM is back in IDLE.
  assign ioctl_wait = ((state == S_LOAD) && (count >= CNTW'(FIFO_DEPTH - 1))) ||
                      (((state == S_DRAIN) || (state == S_HOLD)) && ioctl_download && idx_ok);

  always_comb begin
    slot_size = '0;
    for (int s = 0; s < N_SLOTS; s++) slot_size[s*SZW +: SZW] = size_q[s];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_off[wr_ptr] <= ioctl_addr[SLOT_AW-1:0];
      fifo_dat[wr_ptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HOLD;
      hold_cnt   <= CW'(HOLD_CYC);
      core_reset <= 1'b1;
      slot       <= '0;
      slot_valid <= '0;
      for (int s = 0; s < N_SLOTS; s++) size_q[s] <= '0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FAW'(1);
      rd_ptr <= next_rd;
      count  <= count + CNTW'(push) - CNTW'(pop);

      // Load a new head into the output register only when the port is free.
      if (!mem_we || pop) begin
        if (avail != '0) begin
          mem_we   <= 1'b1;
          mem_addr <= {slot, fifo_off[next_rd]};
          mem_data <= fifo_dat[next_rd];
        end else begin
          mem_we   <= 1'b0;
        end
      end

      if (push && (off_plus1 > size_q[slot])) size_q[slot] <= off_plus1;
      if (drop) overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          if (ioctl_download && idx_ok) begin
            state                <= S_LOAD;
            core_reset           <= 1'b1;
            slot                 <= new_slot;
            slot_valid[new_slot] <= 1'b0;
            size_q[new_slot]     <= '0;
            overflow             <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!ioctl_download) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((count == '0) && !mem_we) begin
            state            <= S_HOLD;
            slot_valid[slot] <= (size_q[slot] != '0);
            hold_cnt         <= CW'(HOLD_CYC);
          end
        end
        S_HOLD: begin
          if (hold_cnt <= CW'(1)) begin
            state      <= S_IDLE;
            core_reset <= 1'b0;
          end else begin
            hold_cnt   <= hold_cnt - CW'(1);
          end
        end
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_cart_loader.sv
module tb_ioctl_cart_loader;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        mem_ack;
  logic [1:0]  slot_valid;
  logic [31:0] slot_size;
  logic        overflow;
  logic        core_reset;

  ioctl_cart_loader dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ack(mem_ack),
    .slot_valid(slot_valid), .slot_size(slot_size),
    .overflow(overflow), .core_reset(core_reset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   n_sent = 0;
  int   n_acked = 0;
  int   ack_mode = 0;   // 0: always ack, 1: every 8th cycle, 2: never
  int   cyc = 0;
  bit   chk_wait = 0;
  bit   load_phase = 0;
  bit   wait_seen = 0;
  bit   hold_prev = 0;
  logic [23:0] prev_ad = '0;
  logic [0:0]  cur_slot = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit acc, input bit last);
    int guard;
    guard = 0;
    while (ioctl_wait && guard < 200) begin
      ioctl_wr = 1'b0;
      tick();
      guard++;
    end
    if (guard >= 200) check("wait_bound", 64'(ioctl_wait), 64'd0);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (last) ioctl_download = 1'b0;
    if (acc) exp_q.push_back({cur_slot, a[14:0], d});
    tick();
    if (acc) n_sent++;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int g;
    g = 0;
    while (core_reset !== 1'b0 && g < limit) begin
      tick();
      g++;
    end
    check(tag, 64'(core_reset), 64'd0);
  endtask

  // Reset was released just before the first edge of this loop: core_reset
  // stays high through 15 more edges and drops on the 16th.
  task automatic hold_check(input string tag);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check(tag, 64'(core_reset), (i < 16) ? 64'd1 : 64'd0);
    end
  endtask

  // Memory acknowledge source.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ack_mode)
        0:       mem_ack = 1'b1;
        1:       mem_ack = ((cyc % 8) == 0);
        default: mem_ack = 1'b0;
      endcase
    end
  end

  // Write monitor: ordered writes, held request stability, wait model.
  always @(negedge clk) begin
    if (ioctl_wait) wait_seen = 1'b1;
    if (chk_wait)
      check("ioctl_wait", 64'(ioctl_wait), 64'(load_phase && ((n_sent - n_acked) >= 3)));
    if (hold_prev && !reset) begin
      check("mem_we_held", 64'(mem_we), 64'd1);
      check("mem_ad_stable", 64'({mem_addr, mem_data}), 64'(prev_ad));
    end
    if (mem_we && mem_ack && !reset) begin
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("write_ad", 64'({mem_addr, mem_data}), 64'(exp_q.pop_front()));
      n_acked++;
    end
    hold_prev = mem_we && !mem_ack && !reset;
    prev_ad   = {mem_addr, mem_data};
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;

    // T1: reset values and 16-cycle core_reset hold
    repeat (3) tick();
    check("t1_core_reset", 64'(core_reset), 64'd1);
    check("t1_wait", 64'(ioctl_wait), 64'd0);
    check("t1_mem_we", 64'(mem_we), 64'd0);
    check("t1_mem_addr", 64'(mem_addr), 64'd0);
    check("t1_mem_data", 64'(mem_data), 64'd0);
    check("t1_slot_valid", 64'(slot_valid), 64'd0);
    check("t1_slot_size", 64'(slot_size), 64'd0);
    check("t1_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;
    hold_check("t1_hold");

    // T2: slot 0, 256 bytes back to back, ack always high
    ack_mode = 0; cur_slot = 1'b0; n_sent = 0; n_acked = 0; wait_seen = 0;
    chk_wait = 1'b1;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick();
    load_phase = 1'b1;
    check("t2_core_reset_load", 64'(core_reset), 64'd1);
    for (int i = 0; i < 256; i++) send_byte(25'(i), 8'(i) ^ 8'h5A, 1'b1, i == 255);
    ioctl_wr = 1'b0;
    load_phase = 1'b0;
    wait_idle("t2_idle", 500);
    check("t2_exp_empty", 64'(exp_q.size()), 64'd0);
    check("t2_wait_seen", 64'(wait_seen), 64'd0);
    check("t2_size0", 64'(slot_size[15:0]), 64'd256);
    check("t2_size1", 64'(slot_size[31:16]), 64'd0);
    check("t2_valid", 64'(slot_valid), 64'b01);
    check("t2_overflow", 64'(overflow), 64'd0);

    // T3: slot 1, 64 bytes, ack every 8th cycle -> back-pressure
    ack_mode = 1; cur_slot = 1'b1; n_sent = 0; n_acked = 0; wait_seen = 0;
    ioctl_index = 8'd2;
    ioctl_download = 1'b1;
    tick();
    load_phase = 1'b1;
    for (int i = 0; i < 64; i++) send_byte(25'(i), ~8'(i), 1'b1, i == 63);
    ioctl_wr = 1'b0;
    load_phase = 1'b0;
    wait_idle("t3_idle", 2000);
    check("t3_exp_empty", 64'(exp_q.size()), 64'd0);
    check("t3_wait_seen", 64'(wait_seen), 64'd1);
    check("t3_valid", 64'(slot_valid), 64'b11);
    check("t3_size1", 64'(slot_size[31:16]), 64'd64);
    check("t3_size0", 64'(slot_size[15:0]), 64'd256);
    check("t3_overflow", 64'(overflow), 64'd0);

    // T4: slot 0, out-of-range byte dropped, top in-range byte sets max size
    ack_mode = 0; cur_slot = 1'b0; n_sent = 0; n_acked = 0;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick();
    load_phase = 1'b1;
    check("t4_valid_cleared", 64'(slot_valid), 64'b10);
    check("t4_size_cleared", 64'(slot_size[15:0]), 64'd0);
    send_byte(25'h8000, 8'hAA, 1'b0, 1'b0);
    check("t4_overflow_set", 64'(overflow), 64'd1);
    check("t4_size_unchanged", 64'(slot_size[15:0]), 64'd0);
    send_byte(25'h7FFF, 8'hC3, 1'b1, 1'b1);
    ioctl_wr = 1'b0;
    load_phase = 1'b0;
    wait_idle("t4_idle", 500);
    check("t4_exp_empty", 64'(exp_q.size()), 64'd0);
    check("t4_overflow", 64'(overflow), 64'd1);
    check("t4_size0", 64'(slot_size[15:0]), 64'd32768);
    check("t4_size1", 64'(slot_size[31:16]), 64'd64);
    check("t4_valid", 64'(slot_valid), 64'b11);

    // T5: index 7 is not a slot -> ignored entirely
    ioctl_index = 8'd7;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      send_byte(25'(i), 8'(i), 1'b0, 1'b0);
      check("t5_core_reset", 64'(core_reset), 64'd0);
      check("t5_mem_we", 64'(mem_we), 64'd0);
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    repeat (4) tick();
    check("t5_mem_we_end", 64'(mem_we), 64'd0);
    check("t5_valid", 64'(slot_valid), 64'b11);
    check("t5_size", 64'(slot_size), {32'd0, 16'd64, 16'd32768});
    check("t5_overflow", 64'(overflow), 64'd1);

    // T6: reset while a write is pending
    chk_wait = 1'b0;
    ack_mode = 2; cur_slot = 1'b1;
    ioctl_index = 8'd2;
    ioctl_download = 1'b1;
    tick();
    load_phase = 1'b1;
    send_byte(25'd0, 8'h11, 1'b1, 1'b0);
    send_byte(25'd1, 8'h22, 1'b1, 1'b0);
    ioctl_wr = 1'b0;
    tick();
    check("t6_mem_we_pending", 64'(mem_we), 64'd1);
    check("t6_mem_ad_pending", 64'({mem_addr, mem_data}), 64'({16'h8000, 8'h11}));
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    check("t6_mem_we_reset", 64'(mem_we), 64'd0);
    check("t6_valid_reset", 64'(slot_valid), 64'd0);
    check("t6_size_reset", 64'(slot_size), 64'd0);
    check("t6_overflow_reset", 64'(overflow), 64'd0);
    check("t6_core_reset", 64'(core_reset), 64'd1);
    check("t6_wait_reset", 64'(ioctl_wait), 64'd0);
    exp_q.delete();
    load_phase = 1'b0;
    reset = 1'b0;
    hold_check("t6_hold");

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
